word_serializer_6bit: RTL
=========================

Name: word_serializer_6bit

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 6-bit serial-in shift register and drives its serial data input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock, with a bit-valid qualifier and an end-of-word strobe.
- A one-word holding buffer allows back-to-back words with no idle bit slot between them.

Parameters:
- WIDTH, 6: word length in bits; must be 2 or greater.
- MSB_FIRST, 1: 1 sends in_data[WIDTH-1] first, so the word lands unchanged on the downstream register's parallel output (q = word); 0 sends in_data[0] first.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialize; the source holds it stable while in_valid=1 and in_ready=0.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- enable  input  1  bit-advance enable; 0 freezes serialization.
- shift_out  output  1  current serial bit; connects to the downstream shift_in.
- shift_valid  output  1  shift_out carries a valid bit.
- word_done  output  1  one-cycle pulse after the last bit of a word is consumed.
- busy  output  1  a word is in flight or buffered.

Behaviour:
Interface and reset:
- Single clock domain. Reset is synchronous and active-high, with clock and reset ports named clk and reset.
- While reset is sampled high at an edge:
  - state goes to IDLE;
  - the shift register, bit counter and hold register clear to 0;
  - hold_full=0, shift_valid=0, word_done=0, shift_out=0, busy=0.
- Inputs are ignored on reset edges.

Handshake and buffering:
- in_ready = !hold_full (combinational). Reading 1 immediately after reset is permitted.
- A word is accepted on a rising edge where in_valid=1 and in_ready=1.

State machine:
- States: IDLE and SHIFT. Internal state: sh_reg[WIDTH-1:0], cnt (0..WIDTH-1), hold_reg, hold_full.
- IDLE:
  - shift_valid=0 and shift_out=0.
  - On accept: load sh_reg=in_data, cnt=0, go to SHIFT.
  - Latency: the first bit appears on shift_out in the cycle after the accept edge.
- SHIFT:
  - shift_valid=1.
  - shift_out = sh_reg[WIDTH-1] when MSB_FIRST=1, otherwise sh_reg[0]. It is registered, with no combinational path from in_data.
- Edge in SHIFT with enable=1 and cnt<WIDTH-1:
  - shift sh_reg toward the output end and zero-fill;
  - cnt++.
- Edge in SHIFT with enable=1 and cnt==WIDTH-1 (last bit consumed), three cases:
  - hold_full=1: load sh_reg=hold_reg, clear hold_full, cnt=0, stay in SHIFT.
  - Otherwise, accept at this edge: load sh_reg=in_data directly, cnt=0, stay in SHIFT.
  - Otherwise: go to IDLE.
- Result: back-to-back words produce a contiguous bit stream with no gap.
- Accept while in SHIFT and not on the last-bit edge: the word goes to hold_reg and hold_full=1. A second word is then blocked (in_ready=0).
- Hold-to-shift and new accept cannot coincide, because in_ready=0 whenever hold_full=1.

enable=0 in SHIFT:
- sh_reg, cnt and hold are frozen.
- shift_valid stays 1 and shift_out stays stable.
- Accepts into an empty hold still occur.

Downstream coupling:
- The consumer samples shift_out on edges where shift_valid && enable.
- The consumer's register must be clocked or gated with the same qualifier.

word_done and busy:
- word_done is registered. It is 1 for exactly one cycle following each last-bit edge, including between back-to-back words.
- busy = (state==SHIFT) || hold_full.

Reset mid-word:
- The in-flight and buffered words are discarded.
- No word_done is generated for them.
- The next word restarts from bit 0.

Test Plan:
1. Single word, WIDTH=6, MSB_FIRST=1, enable=1: accept 6'b101101 -> shift_out 1,0,1,1,0,1 on the 6 cycles after accept, shift_valid high for exactly 6 cycles, word_done pulses once on cycle 7; the downstream 6-bit register reads q=6'b101101.
2. Back-to-back: present 6'h2A then 6'h15 continuously -> 12 contiguous valid bits 101010 010101; in_ready=0 from the cycle after the second accept until the word-1 last-bit edge; two word_done pulses 6 cycles apart.
3. Pause: send 6'b110011, drop enable for 3 cycles after bit 2 -> shift_out holds bit 2 value 0 for 4 cycles, total 9 shift_valid cycles, downstream q=6'b110011, single word_done.
4. Reset mid-word: reset asserted for 1 cycle after bit 3 of 6'h3F with a word 6'h01 held in the buffer -> next cycle all outputs 0, busy=0, in_ready=1, no word_done; a subsequent 6'h01 serializes as 0,0,0,0,0,1.
5. LSB-first, MSB_FIRST=0: accept 6'b000011 -> shift_out 1,1,0,0,0,0.
6. Stall source: in_valid held with hold full -> in_data not consumed until in_ready rises; no words are lost or duplicated across 20 random words, checked by a scoreboard.

Source files
------------

// File: rtl/word_serializer_6bit.sv
// Parallel-in / serial-out word serializer with a one-word holding buffer.
// Words arrive over valid/ready and leave one bit per enabled clock on
// shift_out, qualified by shift_valid, with a word_done pulse per word.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing in flight; shift_valid=0, shift_out=0
// SHIFT | sh_reg holds the word being sent; cnt counts bits consumed
`timescale 1ns/1ps

module word_serializer_6bit #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_reg, sh_reg_n;
  logic [WIDTH-1:0] hold_reg, hold_reg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             word_done_n;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sh_shifted;

  assign in_ready    = !hold_full;
  assign accept      = in_valid && in_ready;
  assign last_bit    = (cnt == LAST);
  // Move the next bit toward the output end, zero-filling behind it.
  assign sh_shifted  = MSB_FIRST ? {sh_reg[WIDTH-2:0], 1'b0}
                                 : {1'b0, sh_reg[WIDTH-1:1]};
  // Outputs depend only on registers, so in_data never reaches shift_out
  // combinationally.
  assign shift_valid = (state == SHIFT);
  assign shift_out   = shift_valid && (MSB_FIRST ? sh_reg[WIDTH-1] : sh_reg[0]);
  assign busy        = shift_valid || hold_full;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh_reg    <= '0;
      hold_reg  <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sh_reg    <= sh_reg_n;
      hold_reg  <= hold_reg_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
      word_done <= word_done_n;
    end
  end

  // Next-state: load, shift, refill from the buffer or a direct accept.
  always_comb begin
    state_n     = state;
    sh_reg_n    = sh_reg;
    hold_reg_n  = hold_reg;
    cnt_n       = cnt;
    hold_full_n = hold_full;
    word_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_reg_n = in_data;
          cnt_n    = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (enable && last_bit) begin
          // Last bit consumed: refill immediately so back-to-back words
          // leave no gap. Buffer and direct accept are mutually exclusive
          // because in_ready is low while the buffer is full.
          word_done_n = 1'b1;
          cnt_n       = '0;
          if (hold_full) begin
            sh_reg_n    = hold_reg;
            hold_full_n = 1'b0;
          end else if (accept) begin
            sh_reg_n = in_data;
          end else begin
            sh_reg_n = '0;
            state_n  = IDLE;
          end
        end else begin
          if (enable) begin
            sh_reg_n = sh_shifted;
            cnt_n    = cnt + 1'b1;
          end
          if (accept) begin
            hold_reg_n  = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
